// File: rtl/frost32_mem_access_unit.sv
// Frost32 load/store unit: queues CPU requests, issues one memory access at a time,
// and returns lane-extracted, size-extended read data or an alignment error.
module frost32_mem_access_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req_valid,
    output logic                    cpu_req_ready,
    input  logic                    cpu_req_type,
    input  logic [1:0]              cpu_req_size,
    input  logic                    cpu_req_signed,
    input  logic [ADDR_WIDTH-1:0]   cpu_req_addr,
    input  logic [31:0]             cpu_req_wdata,
    output logic                    cpu_rsp_valid,
    output logic [31:0]             cpu_rsp_rdata,
    output logic                    cpu_rsp_error,
    output logic                    mem_req,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int SLOTS  = DATA_WIDTH / 32;
    localparam logic [PTR_W:0] COUNT_FULL = (PTR_W + 1)'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        SIZE_32  = 2'd0,
        SIZE_16  = 2'd1,
        SIZE_8   = 2'd2,
        SIZE_BAD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic                  is_write;
        size_e                 size;
        logic                  is_signed;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
    } req_t;

    req_t              fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    state_e            state;

    logic              push;
    logic              pop;
    req_t              head;
    logic              head_err;
    logic [LANE_W-1:0] head_lane;
    logic [BYTES-1:0]  head_be;

    logic [LANE_W-1:0] lane_q;
    size_e             size_q;
    logic              signed_q;
    logic              write_q;
    logic [DATA_WIDTH-1:0] shifted;
    logic [31:0]       rd_ext;

    assign cpu_req_ready = (count != COUNT_FULL);
    assign push          = cpu_req_valid && cpu_req_ready;
    assign pop           = (state == ST_IDLE) && (count != '0);
    assign head          = fifo_mem[rd_ptr];
    assign head_lane     = head.addr[LANE_W-1:0];

    // Decode the head entry: alignment error and byte-lane enables starting at its lane.
    always_comb begin
        head_err = 1'b0;
        head_be  = '0;
        case (head.size)
            SIZE_32: begin
                head_err = (head.addr[1:0] != 2'b00);
                head_be  = BYTES'(4'b1111) << head_lane;
            end
            SIZE_16: begin
                head_err = head.addr[0];
                head_be  = BYTES'(4'b0011) << head_lane;
            end
            SIZE_8: begin
                head_be  = BYTES'(4'b0001) << head_lane;
            end
            default: head_err = 1'b1;
        endcase
    end

    always_comb begin
        shifted = mem_rdata >> {lane_q, 3'b000};
        rd_ext  = '0;
        case (size_q)
            SIZE_32: rd_ext = shifted[31:0];
            SIZE_16: rd_ext = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            SIZE_8:  rd_ext = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            default: rd_ext = '0;
        endcase
        if (write_q) begin
            rd_ext = '0;
        end
    end

    // NOTE: queue storage carries no reset; entries are only read after being written,
    // so clearing them would add reset fan-out for no functional benefit.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= req_t'{
                is_write:  cpu_req_type,
                size:      size_e'(cpu_req_size),
                is_signed: cpu_req_signed,
                addr:      cpu_req_addr,
                wdata:     cpu_req_wdata
            };
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_byte_en   <= '0;
            mem_wdata     <= '0;
            lane_q        <= '0;
            size_q        <= SIZE_32;
            signed_q      <= 1'b0;
            write_q       <= 1'b0;
            cpu_rsp_valid <= 1'b0;
            cpu_rsp_error <= 1'b0;
            cpu_rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        if (head_err) begin
                            cpu_rsp_valid <= 1'b1;
                            cpu_rsp_error <= 1'b1;
                            cpu_rsp_rdata <= '0;
                            state         <= ST_RESP;
                        end else begin
                            mem_req     <= 1'b1;
                            mem_addr    <= {head.addr[ADDR_WIDTH-1:LANE_W], {LANE_W{1'b0}}};
                            mem_we      <= head.is_write;
                            mem_byte_en <= head_be;
                            mem_wdata   <= {SLOTS{head.wdata}};
                            lane_q      <= head_lane;
                            size_q      <= head.size;
                            signed_q    <= head.is_signed;
                            write_q     <= head.is_write;
                            state       <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (mem_ack) begin
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        mem_byte_en   <= '0;
                        cpu_rsp_valid <= 1'b1;
                        cpu_rsp_error <= 1'b0;
                        cpu_rsp_rdata <= rd_ext;
                        state         <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    cpu_rsp_valid <= 1'b0;
                    cpu_rsp_error <= 1'b0;
                    cpu_rsp_rdata <= '0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frost32_mem_access_unit.sv
// Scoreboard bench for frost32_mem_access_unit: byte-addressed memory model, random and
// directed traffic on a 32-bit instance, directed lane checks on a 64-bit instance.
module tb_frost32_mem_access_unit;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cpu_req_valid = 1'b0;
    logic        cpu_req_ready;
    logic        cpu_req_type = 1'b0;
    logic [1:0]  cpu_req_size = 2'd0;
    logic        cpu_req_signed = 1'b0;
    logic [31:0] cpu_req_addr = '0;
    logic [31:0] cpu_req_wdata = '0;
    logic        cpu_rsp_valid;
    logic [31:0] cpu_rsp_rdata;
    logic        cpu_rsp_error;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    logic        v64_valid = 1'b0;
    logic        v64_ready;
    logic        v64_type = 1'b0;
    logic [1:0]  v64_size = 2'd0;
    logic        v64_signed = 1'b0;
    logic [31:0] v64_addr = '0;
    logic [31:0] v64_wdata = '0;
    logic        v64_rsp_valid;
    logic [31:0] v64_rsp_rdata;
    logic        v64_rsp_error;
    logic        v64_mem_req;
    logic [31:0] v64_mem_addr;
    logic        v64_mem_we;
    logic [7:0]  v64_mem_byte_en;
    logic [63:0] v64_mem_wdata;
    logic        v64_mem_ack = 1'b1;
    logic [63:0] v64_mem_rdata = 64'h9122_3344_5566_7788;

    int n_compared = 0;
    int n_mismatched = 0;
    int rsp_count = 0;
    int ack_mode = 1;              // 0 random, 1 always high, 2 always low
    bit txn_seen = 1'b0;
    bit ack_now;

    rsp_t  rsp_q[$];
    mreq_t mreq_q[$];
    rsp_t  e_r;
    mreq_t e_m;
    logic [7:0] model_mem [int unsigned];
    logic [7:0] bus_mem [int unsigned];

    frost32_mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_type(cpu_req_type), .cpu_req_size(cpu_req_size),
        .cpu_req_signed(cpu_req_signed), .cpu_req_addr(cpu_req_addr),
        .cpu_req_wdata(cpu_req_wdata),
        .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_rdata(cpu_rsp_rdata),
        .cpu_rsp_error(cpu_rsp_error),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_byte_en(mem_byte_en), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    frost32_mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .QUEUE_DEPTH(4)) dut64 (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(v64_valid), .cpu_req_ready(v64_ready),
        .cpu_req_type(v64_type), .cpu_req_size(v64_size),
        .cpu_req_signed(v64_signed), .cpu_req_addr(v64_addr),
        .cpu_req_wdata(v64_wdata),
        .cpu_rsp_valid(v64_rsp_valid), .cpu_rsp_rdata(v64_rsp_rdata),
        .cpu_rsp_error(v64_rsp_error),
        .mem_req(v64_mem_req), .mem_addr(v64_mem_addr), .mem_we(v64_mem_we),
        .mem_byte_en(v64_mem_byte_en), .mem_wdata(v64_mem_wdata),
        .mem_ack(v64_mem_ack), .mem_rdata(v64_mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int unsigned a);
        return 8'(a * 37 + 5);
    endfunction

    function automatic logic [7:0] model_rd(input int unsigned a);
        return model_mem.exists(a) ? model_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(input int unsigned a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    // Reference model: byte-addressed memory, in-order single-access semantics.
    function automatic void model_accept(input logic typ, input logic [1:0] sz, input logic sgn,
                                         input logic [31:0] addr, input logic [31:0] wdata);
        int          n;
        int unsigned lane;
        logic [63:0] val;
        case (sz)
            2'd0:    n = 4;
            2'd1:    n = 2;
            2'd2:    n = 1;
            default: n = 0;
        endcase
        if (n == 0 || (addr % n) != 0) begin
            rsp_q.push_back('{is_err: 1'b1, rdata: 32'h0});
        end else begin
            lane = addr % 4;
            mreq_q.push_back('{addr: addr - lane, we: typ,
                               be: 4'(((1 << n) - 1) << lane), wdata: wdata});
            if (typ) begin
                for (int i = 0; i < n; i++)
                    model_mem[addr + i] = 8'(wdata >> (8 * ((addr + i) % 4)));
                rsp_q.push_back('{is_err: 1'b0, rdata: 32'h0});
            end else begin
                val = '0;
                for (int i = 0; i < n; i++)
                    val |= 64'(model_rd(addr + i)) << (8 * i);
                if (sgn && val[8*n-1])
                    val |= ~((64'd1 << (8 * n)) - 64'd1);
                rsp_q.push_back('{is_err: 1'b0, rdata: val[31:0]});
            end
        end
    endfunction

    task automatic issue(input logic typ, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n = 0;
        cpu_req_type   = typ;
        cpu_req_size   = sz;
        cpu_req_signed = sgn;
        cpu_req_addr   = addr;
        cpu_req_wdata  = wdata;
        cpu_req_valid  = 1'b1;
        while (!cpu_req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!cpu_req_ready) begin
            check("req_ready_timeout", cpu_req_ready, 1);
            cpu_req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(typ, sz, sgn, addr, wdata);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (rsp_q.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_queue_empty", rsp_q.size(), 0);
    endtask

    task automatic issue64(input logic typ, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_addr, input logic [7:0] exp_be,
                           input logic [63:0] exp_wdata, input logic [31:0] exp_rdata);
        v64_type   = typ;
        v64_size   = sz;
        v64_signed = sgn;
        v64_addr   = addr;
        v64_wdata  = wdata;
        v64_valid  = 1'b1;
        check("w64_ready", v64_ready, 1);
        @(posedge clk); #1;
        v64_valid = 1'b0;
        @(posedge clk); #1;
        check("w64_mem_req", v64_mem_req, 1);
        check("w64_mem_addr", v64_mem_addr, exp_addr);
        check("w64_mem_byte_en", v64_mem_byte_en, exp_be);
        check("w64_mem_we", v64_mem_we, typ);
        check("w64_mem_wdata", v64_mem_wdata, exp_wdata);
        @(posedge clk); #1;
        check("w64_rsp_valid", v64_rsp_valid, 1);
        check("w64_rsp_error", v64_rsp_error, 0);
        check("w64_rsp_rdata", v64_rsp_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    // Memory responder: checks each new transaction against the model, then serves it.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_ack  = 1'b0;
            txn_seen = 1'b0;
        end else if (mem_req) begin
            if (!txn_seen) begin
                txn_seen = 1'b1;
                if (mreq_q.size() == 0) begin
                    check("mem_unexpected", mem_req, 0);
                end else begin
                    e_m = mreq_q.pop_front();
                    check("mem_addr", mem_addr, e_m.addr);
                    check("mem_we", mem_we, e_m.we);
                    check("mem_byte_en", mem_byte_en, e_m.be);
                    check("mem_wdata", mem_wdata, e_m.wdata);
                end
            end
            ack_now = (ack_mode == 1) || (ack_mode == 0 && $urandom_range(0, 2) == 0);
            mem_ack = ack_now;
            if (ack_now) begin
                if (mem_we) begin
                    for (int i = 0; i < 4; i++)
                        if (mem_byte_en[i]) bus_mem[mem_addr + i] = mem_wdata[8*i +: 8];
                end else begin
                    mem_rdata = {bus_rd(mem_addr + 3), bus_rd(mem_addr + 2),
                                 bus_rd(mem_addr + 1), bus_rd(mem_addr)};
                end
            end
        end else begin
            txn_seen  = 1'b0;
            mem_ack   = (ack_mode == 1) || (ack_mode == 0 && $urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    // Response monitor: pops the expected response whenever the DUT presents one.
    always @(negedge clk) begin
        if (rst_n && cpu_rsp_valid) begin
            rsp_count++;
            if (rsp_q.size() == 0) begin
                check("rsp_unexpected", cpu_rsp_valid, 0);
            end else begin
                e_r = rsp_q.pop_front();
                check("rsp_error", cpu_rsp_error, e_r.is_err);
                check("rsp_rdata", cpu_rsp_rdata, e_r.rdata);
            end
        end
    end

    initial begin
        int n;
        int saved;
        logic [1:0]  sz;
        logic [31:0] a;

        #3;
        check("rst_req_ready", cpu_req_ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_byte_en", mem_byte_en, 0);
        check("rst_rsp_valid", cpu_rsp_valid, 0);
        check("rst_rsp_error", cpu_rsp_error, 0);
        check("rst_rsp_rdata", cpu_rsp_rdata, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Signed byte read from the top lane.
        model_mem[32'h1000] = 8'hFF; model_mem[32'h1001] = 8'hFF;
        model_mem[32'h1002] = 8'hFF; model_mem[32'h1003] = 8'h80;
        bus_mem[32'h1000] = 8'hFF; bus_mem[32'h1001] = 8'hFF;
        bus_mem[32'h1002] = 8'hFF; bus_mem[32'h1003] = 8'h80;
        ack_mode = 1;
        issue(1'b0, 2'd2, 1'b1, 32'h1003, 32'h0);
        @(posedge clk); #1;
        check("sbyte_mem_req", mem_req, 1);
        check("sbyte_mem_addr", mem_addr, 32'h1000);
        check("sbyte_mem_byte_en", mem_byte_en, 4'b1000);
        @(posedge clk); #1;
        check("sbyte_rsp_valid_n2", cpu_rsp_valid, 1);
        check("sbyte_rsp_rdata", cpu_rsp_rdata, 32'hFFFF_FF80);
        @(posedge clk); #1;
        check("sbyte_rsp_one_cycle", cpu_rsp_valid, 0);

        // Misaligned word and bad size: error after one edge, no memory access.
        issue(1'b0, 2'd0, 1'b0, 32'h2, 32'h0);
        @(posedge clk); #1;
        check("misalign_rsp_valid", cpu_rsp_valid, 1);
        check("misalign_rsp_error", cpu_rsp_error, 1);
        check("misalign_mem_req", mem_req, 0);
        @(posedge clk); #1;
        check("misalign_mem_req_after", mem_req, 0);
        issue(1'b1, 2'd3, 1'b0, 32'h100, 32'h1234);
        @(posedge clk); #1;
        check("badsize_rsp_error", cpu_rsp_error, 1);
        check("badsize_mem_req", mem_req, 0);
        drain(20);

        // Queue full: one in flight plus four queued.
        ack_mode = 2;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, 2'd0, 1'b0, 32'h100 + 32'(4 * i), 32'h0);
            if (i == 3) check("full_ready_after_4", cpu_req_ready, 1);
        end
        check("full_ready_after_5", cpu_req_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        check("full_ready_held", cpu_req_ready, 0);
        ack_mode = 1;
        @(posedge clk); #1;
        check("full_ready_at_ack", cpu_req_ready, 0);
        n = 0;
        while (!cpu_req_ready && n < 4) begin
            @(posedge clk); #1;
            n++;
        end
        check("full_ready_rises", cpu_req_ready, 1);
        drain(100);

        // Randomised traffic with random memory latency and spurious idle acks.
        ack_mode = 0;
        for (int i = 0; i < 300; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            sz = 2'($urandom_range(0, 3));
            a  = 32'h100 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) begin
                if (sz == 2'd0) a = a & ~32'h3;
                if (sz == 2'd1) a = a & ~32'h1;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end
        drain(3000);
        check("mem_queue_empty", mreq_q.size(), 0);

        // Reset while a read is outstanding and more are queued.
        ack_mode = 2;
        for (int i = 0; i < 3; i++) issue(1'b0, 2'd0, 1'b0, 32'h108, 32'h0);
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy_mem_req_before_reset", mem_req, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("busy_reset_mem_req", mem_req, 0);
        check("busy_reset_ready", cpu_req_ready, 1);
        check("busy_reset_rsp_valid", cpu_rsp_valid, 0);
        rsp_q.delete();
        mreq_q.delete();
        saved = rsp_count;
        ack_mode = 1;
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("busy_reset_no_rsp", rsp_count, saved);
        check("busy_reset_mem_idle", mem_req, 0);

        // 64-bit bus lane placement and extraction.
        issue64(1'b1, 2'd1, 1'b0, 32'h06, 32'h0000_BEEF,
                32'h0, 8'b1100_0000, 64'h0000_BEEF_0000_BEEF, 32'h0);
        issue64(1'b0, 2'd2, 1'b1, 32'h0D, 32'h0,
                32'h08, 8'b0010_0000, 64'h0, 32'h0000_0033);
        issue64(1'b0, 2'd1, 1'b1, 32'h16, 32'h0,
                32'h10, 8'b1100_0000, 64'h0, 32'hFFFF_9122);
        issue64(1'b0, 2'd0, 1'b0, 32'h24, 32'h0,
                32'h20, 8'b1111_0000, 64'h0, 32'h9122_3344);
        issue64(1'b0, 2'd2, 1'b0, 32'h07, 32'h0,
                32'h00, 8'b1000_0000, 64'h0, 32'h0000_0091);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
